// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one sequential multiplier among N requesters
module mul_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] a_bi,
  input  logic [N*W-1:0] b_bi,
  output logic [N-1:0]   grant_o,
  output logic [N-1:0]   done_o,
  output logic [2*W-1:0] y_bo,
  output logic           busy_o,
  output logic [W-1:0]   mul_a_bo,
  output logic [W-1:0]   mul_b_bo,
  output logic           mul_start_o,
  input  logic           mul_busy_i,
  input  logic [2*W-1:0] mul_y_bi
);

  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          zero_seen;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  int            j;

  // First requester after the last one served, wrapping modulo N.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!pick_valid && req_i[j]) begin
        pick_valid = 1'b1;
        pick_idx   = j[IW-1:0];
      end
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= IW'(N - 1);
      gidx        <= '0;
      zero_seen   <= 1'b0;
      grant_o     <= '0;
      done_o      <= '0;
      y_bo        <= '0;
      mul_a_bo    <= '0;
      mul_b_bo    <= '0;
      mul_start_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gidx        <= pick_idx;
            grant_o     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            mul_a_bo    <= a_bi[pick_idx*W +: W];
            mul_b_bo    <= b_bi[pick_idx*W +: W];
            mul_start_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_o <= 1'b0;
          zero_seen   <= 1'b0;
          state       <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A multiplier that never raises busy is treated as a zero-latency completion.
          if (mul_busy_i) begin
            state <= WAIT_DONE;
          end else if (zero_seen) begin
            y_bo   <= mul_y_bi;
            done_o <= grant_o;
            state  <= RESP;
          end else begin
            zero_seen <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!mul_busy_i) begin
            y_bo   <= mul_y_bi;
            done_o <= grant_o;
            state  <= RESP;
          end
        end
        RESP: begin
          ptr     <= gidx;
          done_o  <= '0;
          grant_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier (`mul`: start_i, busy_o, y_bo) between N requesters.
- Accepts operand pairs from requesters and issues one multiply at a time. Waits for the multiplier to finish, then returns the 16-bit product to the granted requester with a one-cycle done pulse.
- Sits between client blocks and a single `mul` instance; drives that instance's a_bi, b_bi and start_i.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand width; product width is 2*W

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_i  in  N  per-requester request level
a_bi  in  N*W  packed operand A, requester k at [k*W +: W]
b_bi  in  N*W  packed operand B, same packing
grant_o  out  N  one-hot, requester currently owning the multiplier
done_o  out  N  one-hot one-cycle pulse, product on y_bo valid for that requester
y_bo  out  2*W  product of the last completed operation
busy_o  out  1  high whenever state is not IDLE
mul_a_bo  out  W  operand A to multiplier
mul_b_bo  out  W  operand B to multiplier
mul_start_o  out  1  start pulse to multiplier
mul_busy_i  in  1  multiplier busy
mul_y_bi  in  2*W  multiplier product

Behaviour:
- Reset (async, rst_i=1): state=IDLE; grant_o=0, done_o=0, y_bo=0, busy_o=0, mul_start_o=0, mul_a_bo=0, mul_b_bo=0; rr pointer=N-1, so requester 0 has top priority first.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_i is set, pick the first set bit searching from pointer+1 upward, wrapping modulo N.
  - Register grant_o one-hot and latch that requester's a/b into mul_a_bo/mul_b_bo. Go to ISSUE.
  - If no req_i is set, stay in IDLE.
- ISSUE: mul_start_o=1 for exactly this one cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - mul_start_o=0; wait for mul_busy_i=1, then go to WAIT_DONE.
  - If mul_busy_i is already 0 for 2 consecutive cycles here, treat the operation as a zero-latency completion and go to RESP.
- WAIT_DONE: on mul_busy_i=0, capture mul_y_bi into y_bo and go to RESP.
- RESP:
  - done_o = grant_o for one cycle; pointer = granted index.
  - Clear grant_o next cycle and return to IDLE.
- Latency: req_i rise to start pulse is 2 cycles. Total is 2 + 1 (WAIT_BUSY) + multiplier busy cycles + 1 (RESP).
- No new grant is issued in the RESP cycle; back-to-back grants are separated by at least one IDLE cycle.
- Operands are latched at grant. Requester changes to a/b after grant do not affect the running operation.
- A requester that drops req_i after grant still completes and receives done_o; the result is not discarded.
- A requester that drops req_i before grant is simply not selected.
- Requesters must deassert req_i in the cycle after their done_o pulse; otherwise they re-enter arbitration at lowest priority.
- y_bo holds its value until the next capture; it is never cleared except by reset.
- busy_o = (state != IDLE).
- Reset mid-operation: all outputs return to reset values immediately. Any in-flight result is lost and no done_o is emitted. The multiplier is reset by the same rst_i.
- The multiplier must latch operands on the mul_start_o pulse while not busy.

Test Plan:
- Single requester: req_i=0001, a0=3, b0=5 -> one mul_start_o pulse; done_o=0001 once; y_bo=15; grant_o returns to 0.
- Max operands: req_i=0100, a2=b2=255 -> y_bo=65025, done_o=0100.
- Simultaneous req_i=0011 (a0=2,b0=7; a1=4,b1=4) after reset -> requester 0 served first (y_bo=14), then requester 1 (y_bo=16); ≥1 IDLE cycle between grants.
- Fairness: all four held high with a_k=b_k=k+1 -> done_o order 0001,0010,0100,1000,0001; y_bo sequence 1,4,9,16,1.
- Operand change after grant: a0 changes 6→9 during WAIT_DONE with b0=6 -> y_bo=36.
- Reset mid-op: rst_i pulsed during WAIT_DONE -> outputs go to zero within the same cycle; no done_o; next request completes normally with the correct product.
